// File: rtl/if_fetch_buffer.sv
// Instruction fetch stage: issues single-outstanding imem requests from the PC
// register, queues returned {pc, inst} pairs and drives the registered IF/ID outputs.
module if_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          ce_i,
  input  logic [5:0]    stall,
  input  logic          flush,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          stallreq_o,
  output logic [AW-1:0] id_pc_o,
  output logic [DW-1:0] id_inst_o,
  output logic          id_valid_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        r_state, w_state_n;
  logic [PW:0]   r_count;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW-1:0] r_mem_pc   [DEPTH];
  logic [DW-1:0] r_mem_inst [DEPTH];

  logic w_busy, w_free, w_ack_wait, w_accept, w_push, w_pop, w_unused;

  // An outstanding request reserves a FIFO slot so its data always has room.
  assign w_busy     = (r_state != IDLE);
  assign w_free     = ({1'b0, r_count} + {{(PW+1){1'b0}}, w_busy}) < (PW+2)'(DEPTH);
  assign w_ack_wait = (r_state == WAIT) & imem_ack_i;
  assign w_accept   = ce_i & ~flush & w_free & ((r_state == IDLE) | w_ack_wait);
  assign w_push     = ~flush & w_ack_wait;
  assign w_pop      = ~flush & ~stall[1] & (r_count != '0);
  assign stallreq_o = ce_i & ~w_accept;
  assign w_unused   = ^{stall[5:3], stall[0]};

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_n = WAIT;
      WAIT: begin
        if (imem_ack_i)  w_state_n = w_accept ? WAIT : IDLE;
        else if (flush)  w_state_n = DROP;
      end
      DROP: if (imem_ack_i) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      r_state    <= w_state_n;
      imem_req_o <= (w_state_n != IDLE);
      if (w_accept) imem_addr_o <= pc_i;
    end
  end

  // Storage needs no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_pc[r_wr_ptr]   <= imem_addr_o;
      r_mem_inst[r_wr_ptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // stall[1] with stall[2] held keeps the current instruction in ID;
  // stall[1] alone inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else if (stall[1]) begin
      if (!stall[2]) begin
        id_pc_o    <= '0;
        id_inst_o  <= '0;
        id_valid_o <= 1'b0;
      end
    end else if (r_count != '0) begin
      id_pc_o    <= r_mem_pc[r_rd_ptr];
      id_inst_o  <= r_mem_inst[r_rd_ptr];
      id_valid_o <= 1'b1;
    end else begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: reset/fetch vector table, corner-case sequences and
// a randomized run against a queue-based reference model.
module tb_if_fetch_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        ce = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        req_o, sr_o, v_o;
  logic [31:0] addr_o, idpc_o, idinst_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .stall(stall), .flush(flush),
    .imem_req_o(req_o), .imem_addr_o(addr_o), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .stallreq_o(sr_o), .id_pc_o(idpc_o), .id_inst_o(idinst_o), .id_valid_o(v_o)
  );

  // Reference model: one outstanding-fetch flag (with a keep/discard bit),
  // a queue of fetched pairs, and the ID register contents.
  logic        m_out = 0, m_keep = 0, m_acc = 0, m_sr = 0, last_acc = 0;
  logic [31:0] m_addr = 0, m_id_pc = 0, m_id_inst = 0;
  logic        m_id_v = 0;
  logic [31:0] q_pc[$], q_inst[$];

  function automatic void m_comb();
    m_acc = ce && !flush && ((q_pc.size() + int'(m_out)) < DEPTH) && (!m_out || (m_keep && ack));
    m_sr  = ce && !m_acc;
  endfunction

  function automatic void m_update();
    logic took;
    m_comb();
    last_acc = m_acc && !rst;
    if (rst) begin
      m_out = 0; m_keep = 0; m_addr = 0;
      m_id_pc = 0; m_id_inst = 0; m_id_v = 0;
      q_pc.delete(); q_inst.delete();
      return;
    end
    took = m_out && m_keep && ack && !flush;
    if (flush || (stall[1] && !stall[2]) || (!stall[1] && q_pc.size() == 0)) begin
      m_id_pc = 0; m_id_inst = 0; m_id_v = 0;
    end else if (!stall[1]) begin
      m_id_pc = q_pc.pop_front(); m_id_inst = q_inst.pop_front(); m_id_v = 1;
    end
    if (took) begin q_pc.push_back(m_addr); q_inst.push_back(rdata); end
    if (flush) begin q_pc.delete(); q_inst.delete(); end
    if (m_out && ack) m_out = 0;
    else if (m_out && flush) m_keep = 0;
    if (m_acc) begin m_out = 1; m_keep = 1; m_addr = pc; end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: combinational stall request checked before the edge,
  // registered outputs checked 1 unit after it.
  task automatic cycle();
    #1;
    m_comb();
    chk("stallreq", 32'(sr_o), 32'(m_sr));
    @(posedge clk);
    m_update();
    #1;
    chk("imem_req", 32'(req_o), 32'(m_out));
    chk("imem_addr", addr_o, m_addr);
    chk("id_valid", 32'(v_o), 32'(m_id_v));
    chk("id_pc", idpc_o, m_id_pc);
    chk("id_inst", idinst_o, m_id_inst);
  endtask

  task automatic do_reset();
    rst = 1; ce = 0; flush = 0; stall = '0; ack = 0; pc = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  // Fetch with immediate acks; PC advances whenever the last one was accepted.
  task automatic fetch(input int n);
    repeat (n) begin
      ack = m_out; rdata = $urandom;
      cycle();
      if (last_acc) pc = pc + 4;
    end
  endtask

  typedef struct {
    logic        rst, ce;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_sr, e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] got[$];
    // rst ce pc ack rdata | stallreq req addr valid id_pc id_inst
    tbl[0] = '{1, 0, 32'h0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0, 32'h0};
    tbl[1] = '{1, 0, 32'h0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0, 32'h0};
    tbl[2] = '{0, 1, 32'h0, 0, 32'h0,         0, 1, 32'h0, 0, 32'h0, 32'h0};
    tbl[3] = '{0, 1, 32'h4, 1, 32'hA000_0000, 0, 1, 32'h4, 0, 32'h0, 32'h0};
    tbl[4] = '{0, 1, 32'h8, 1, 32'hA000_0004, 0, 1, 32'h8, 1, 32'h0, 32'hA000_0000};
    tbl[5] = '{0, 1, 32'hC, 1, 32'hA000_0008, 0, 1, 32'hC, 1, 32'h4, 32'hA000_0004};
    tbl[6] = '{0, 0, 32'hC, 0, 32'h0,         0, 1, 32'hC, 1, 32'h8, 32'hA000_0008};
    tbl[7] = '{0, 0, 32'hC, 1, 32'hA000_000C, 0, 0, 32'hC, 0, 32'h0, 32'h0};
    tbl[8] = '{0, 0, 32'hC, 0, 32'h0,         0, 0, 32'hC, 1, 32'hC, 32'hA000_000C};
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; ce = tbl[i].ce; pc = tbl[i].pc; ack = tbl[i].ack; rdata = tbl[i].rdata;
      #1;
      chk($sformatf("tbl%0d_stallreq", i), 32'(sr_o), 32'(tbl[i].e_sr));
      cycle();
      chk($sformatf("tbl%0d_req", i), 32'(req_o), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i), addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(v_o), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_pc", i), idpc_o, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), idinst_o, tbl[i].e_inst);
    end

    // FIFO full: ID held, four fetches fill the queue, fifth is refused.
    do_reset();
    ce = 1; stall = 6'b000110;
    fetch(6);
    #1;
    chk("full_stallreq", 32'(sr_o), 32'd1);
    chk("full_req", 32'(req_o), 32'd0);
    stall = '0;
    repeat (10) begin
      ack = m_out; rdata = $urandom;
      cycle();
      if (last_acc) pc = pc + 4;
      if (v_o) got.push_back(idpc_o);
    end
    chk("full_drain_cnt", 32'(got.size() >= 5), 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("full_order%0d", i), (got.size() > i) ? got[i] : 32'hFFFF_FFFF, 32'(i * 4));

    // Flush while WAIT, late ack discarded, next fetch delivered.
    do_reset();
    ce = 1; pc = 32'h10; cycle();
    ce = 0; flush = 1; cycle();
    chk("drop_req_held", 32'(req_o), 32'd1);
    flush = 0; cycle();
    ack = 1; rdata = 32'hDEAD_BEEF; cycle();
    chk("drop_req_clr", 32'(req_o), 32'd0);
    ack = 0; cycle();
    chk("drop_no_valid", 32'(v_o), 32'd0);
    ce = 1; pc = 32'h20; rdata = 32'hC0DE_0020;
    got.delete();
    repeat (6) begin
      ack = m_out;
      cycle();
      if (last_acc) ce = 0;
      if (v_o) got.push_back(idinst_o);
    end
    chk("drop_next_cnt", 32'(got.size()), 32'd1);
    chk("drop_next_inst", (got.size() > 0) ? got[0] : 32'h0, 32'hC0DE_0020);

    // Flush on the same edge as the ack: data lost, no accept.
    do_reset();
    ce = 1; pc = 32'h30; cycle();
    flush = 1; ack = 1; pc = 32'h34; rdata = 32'h1234_5678;
    #1;
    chk("flushack_stallreq", 32'(sr_o), 32'd1);
    cycle();
    chk("flushack_req", 32'(req_o), 32'd0);
    flush = 0; ack = 0; ce = 0; cycle();
    chk("flushack_valid", 32'(v_o), 32'd0);

    // ID bubble with a non-empty FIFO, then head delivered unchanged.
    do_reset();
    ce = 1; stall = 6'b000110;
    fetch(3);
    ce = 0; fetch(1);
    stall = 6'b000010; cycle();
    chk("bubble_valid", 32'(v_o), 32'd0);
    chk("bubble_inst", idinst_o, 32'd0);
    stall = '0; cycle();
    chk("bubble_head_v", 32'(v_o), 32'd1);
    chk("bubble_head_pc", idpc_o, 32'h0);

    // Reset with a request outstanding and three queued entries.
    do_reset();
    ce = 1; stall = 6'b000110;
    fetch(4);
    rst = 1; ce = 0; ack = 0; cycle();
    chk("rstmid_req", 32'(req_o), 32'd0);
    chk("rstmid_valid", 32'(v_o), 32'd0);
    rst = 0; ack = 1; cycle();
    chk("rstmid_lateack", 32'(req_o), 32'd0);
    ack = 0; stall = '0; cycle();
    chk("rstmid_empty", 32'(v_o), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    repeat (3000) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 19) == 0);
      ce    = ($urandom_range(0, 3) != 0);
      stall = {3'b000, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'b0};
      ack   = m_out ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      rdata = $urandom;
      if (last_acc || $urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
